// File: rtl/xmul_issuer.sv
// Requester for the xmul multiplier: credit-gated command issue, fixed-latency response capture, FWFT result FIFO.
// Optional per-tag hazard blocking is enabled by defining XMUL_ISSUER_HAZARD_EN.
module xmul_issuer #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dw,
    input  logic [5:0]  cmd_fn,
    input  logic [4:0]  cmd_tag,
    input  logic [63:0] cmd_in1,
    input  logic [63:0] cmd_in2,
    input  logic [63:0] cmd_in3,
    output logic        cmd_err,
    output logic        req_valid,
    output logic        req_bits_dw,
    output logic [5:0]  req_bits_fn,
    output logic [4:0]  req_bits_tag,
    output logic [63:0] req_bits_in1,
    output logic [63:0] req_bits_in2,
    output logic [63:0] req_in3,
    input  logic [63:0] resp_data,
    input  logic [4:0]  resp_tag,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_tag,
    output logic [63:0] wb_data,
    output logic        idle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] trk_vld_q, trk_vld_d;
    logic [4:0]         trk_tag_q [LATENCY];
    logic [4:0]         trk_tag_d [LATENCY];
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [68:0]        mem_q [DEPTH];
    logic [68:0]        mem_d [DEPTH];

    logic [OW-1:0] inflight, occ;
    logic [AW:0]   count;
    logic          legal, hazard, push, pop;
    logic [68:0]   head;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + OW'(trk_vld_q[i]);
        end
        count = wr_ptr_q - rd_ptr_q;
        occ   = inflight + OW'(count);
        idle  = (inflight == '0) && (count == '0);
    end

    always_comb begin
        legal     = cmd_fn inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd50, 6'd51};
        // Credit test uses last cycle's occupancy; same-cycle pops are not credited.
        cmd_ready = reset && (occ < OW'(DEPTH)) && !hazard;
        req_valid = cmd_valid && cmd_ready && legal;
        cmd_err   = cmd_valid && cmd_ready && !legal;

        req_bits_dw  = req_valid ? cmd_dw  : 1'b0;
        req_bits_fn  = req_valid ? cmd_fn  : '0;
        req_bits_tag = req_valid ? cmd_tag : '0;
        req_bits_in1 = req_valid ? cmd_in1 : '0;
        req_bits_in2 = req_valid ? cmd_in2 : '0;
        req_in3      = req_valid ? cmd_in3 : '0;
    end

    always_comb begin
        trk_vld_d    = '0;
        trk_vld_d[0] = req_valid;
        trk_tag_d[0] = req_bits_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_tag_d[i] = trk_tag_q[i-1];
        end
    end

    always_comb begin
        head     = mem_q[rd_ptr_q[AW-1:0]];
        wb_valid = (wr_ptr_q != rd_ptr_q);
        wb_tag   = wb_valid ? head[68:64] : '0;
        wb_data  = wb_valid ? head[63:0]  : '0;

        push     = trk_vld_q[LATENCY-1];
        pop      = wb_valid && wb_ready;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {resp_tag, resp_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trk_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) trk_tag_q[i] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            trk_vld_q <= trk_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int unsigned i = 0; i < LATENCY; i++) trk_tag_q[i] <= trk_tag_d[i];
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

`ifdef XMUL_ISSUER_HAZARD_EN
    logic [31:0] busy_q, busy_d;

    // Busy is registered, so a tag popped this cycle still blocks a same-tag command for one cycle.
    always_comb begin
        hazard = busy_q[cmd_tag];
        busy_d = busy_q;
        if (pop) begin
            busy_d[wb_tag] = 1'b0;
        end
        if (req_valid && (cmd_tag != 5'd0)) begin
            busy_d[cmd_tag] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    always_comb begin
        hazard = 1'b0;
    end
`endif

    a_resp_tag_match: assert property (@(posedge clock) disable iff (!reset)
        trk_vld_q[LATENCY-1] |-> (resp_tag == trk_tag_q[LATENCY-1]));

endmodule

// File: tb/tb_xmul_issuer.sv
// Self-checking bench for xmul_issuer: directed scenarios plus random traffic against a queue-based model of
// outstanding operations; includes a behavioural fixed-latency xmul.
module tb_xmul_issuer;

    localparam int LAT = 2;
    localparam int DEP = 4;

    logic        clock, reset;
    logic        cmd_valid, cmd_ready, cmd_dw, cmd_err;
    logic [5:0]  cmd_fn;
    logic [4:0]  cmd_tag;
    logic [63:0] cmd_in1, cmd_in2, cmd_in3;
    logic        req_valid, req_bits_dw;
    logic [5:0]  req_bits_fn;
    logic [4:0]  req_bits_tag;
    logic [63:0] req_bits_in1, req_bits_in2, req_in3;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        wb_valid, wb_ready, idle;
    logic [4:0]  wb_tag;
    logic [63:0] wb_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    xmul_issuer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dw(cmd_dw), .cmd_fn(cmd_fn),
        .cmd_tag(cmd_tag), .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_in3(cmd_in3),
        .cmd_err(cmd_err), .req_valid(req_valid), .req_bits_dw(req_bits_dw),
        .req_bits_fn(req_bits_fn), .req_bits_tag(req_bits_tag), .req_bits_in1(req_bits_in1),
        .req_bits_in2(req_bits_in2), .req_in3(req_in3), .resp_data(resp_data),
        .resp_tag(resp_tag), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1);
    end

    function automatic logic [63:0] xf(input logic dw, input logic [5:0] fn,
                                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [127:0] sa, sb, ua, ub, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        case (fn)
            6'd0: begin p = ua * ub; return dw ? p[63:0] : {{32{p[31]}}, p[31:0]}; end
            6'd1: begin p = sa * sb; return p[127:64]; end
            6'd2: begin p = sa * ub; return p[127:64]; end
            6'd3: begin p = ua * ub; return p[127:64]; end
            6'd50: begin p = ua * ub; return {13'd0, p[50:0]} + c; end
            6'd51: begin p = ua * ub; return p[114:51] + c; end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] fn);
        case (fn)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd50, 6'd51: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural xmul: fixed-latency pipe; garbage on the bus when nothing is returning.
    logic        pv [LAT];
    logic [4:0]  pt [LAT];
    logic [63:0] pd [LAT];
    always @(posedge clock) begin
        pv[0] <= req_valid;
        pt[0] <= req_bits_tag;
        pd[0] <= xf(req_bits_dw, req_bits_fn, req_bits_in1, req_bits_in2, req_in3);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pt[i] <= pt[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign resp_data = (pv[LAT-1] === 1'b1) ? pd[LAT-1] : 64'hDEAD_BEEF_0BAD_F00D;
    assign resp_tag  = pt[LAT-1];

    // Model: every issued op is outstanding until popped; it becomes visible LAT+1 cycles after issue.
    typedef struct {
        logic [4:0]  tag;
        logic [63:0] data;
        int          cyc;
    } ent_t;
    ent_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", name, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic dw, input logic [5:0] fn, input logic [4:0] tag,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic wbr, output logic acc, output logic ordy);
        logic busy, e_ready, e_acc, e_req, e_err, e_wbv;
        logic [4:0]  e_tag;
        logic [63:0] e_data;
        cmd_valid = v; cmd_dw = dw; cmd_fn = fn; cmd_tag = tag;
        cmd_in1 = a; cmd_in2 = b; cmd_in3 = c; wb_ready = wbr;
        #1;
        busy = 1'b0;
`ifdef XMUL_ISSUER_HAZARD_EN
        foreach (exp_q[i]) if (exp_q[i].tag == tag && tag != 5'd0) busy = 1'b1;
`endif
        e_ready = (exp_q.size() < DEP) && !busy;
        e_acc   = v && e_ready;
        e_req   = e_acc && is_legal(fn);
        e_err   = e_acc && !is_legal(fn);
        e_wbv   = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + LAT + 1);
        e_tag   = e_wbv ? exp_q[0].tag  : 5'd0;
        e_data  = e_wbv ? exp_q[0].data : 64'd0;
        chk("cmd_ready", cmd_ready, e_ready);
        chk("req_valid", req_valid, e_req);
        chk("cmd_err", cmd_err, e_err);
        chk("req_ctl", {req_bits_dw, req_bits_fn, req_bits_tag}, e_req ? {dw, fn, tag} : 12'd0);
        chk("req_in1", req_bits_in1, e_req ? a : 64'd0);
        chk("req_in2", req_bits_in2, e_req ? b : 64'd0);
        chk("req_in3", req_in3, e_req ? c : 64'd0);
        chk("wb_valid", wb_valid, e_wbv);
        chk("wb_tag", wb_tag, e_tag);
        chk("wb_data", wb_data, e_data);
        chk("idle", idle, exp_q.size() == 0);
        ordy = cmd_ready;
        acc  = e_acc;
        if (e_wbv && wbr) void'(exp_q.pop_front());
        if (e_req) exp_q.push_back('{tag: tag, data: xf(dw, fn, a, b, c), cyc: cyc});
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_step(input logic wbr);
        logic a, r;
        step(1'b0, 1'b0, 6'd0, 5'd0, 64'd0, 64'd0, 64'd0, wbr, a, r);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle_step(1'b1);
        idle_step(1'b1);
        chk(name, idle, 1'b1);
    endtask

    initial begin
        logic acc, ordy;
        int k, dacc, cnt;
        logic [5:0] rf;

        reset = 1'b0; cmd_valid = 1'b1; cmd_dw = 1'b0; cmd_fn = 6'd0; cmd_tag = 5'd1;
        cmd_in1 = 64'd1; cmd_in2 = 64'd1; cmd_in3 = 64'd0; wb_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_in1", req_bits_in1, 64'd0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_tag", wb_tag, 5'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_idle", idle, 1'b1);
        cmd_valid = 1'b0;
        reset = 1'b1;

        // 1: MADDL 3*5+7, result visible two cycles after the accept edge
        step(1'b1, 1'b1, 6'd50, 5'd4, 64'd3, 64'd5, 64'd7, 1'b0, acc, ordy);
        idle_step(1'b0);
        idle_step(1'b0);
        chk("t1_wb_valid", wb_valid, 1'b1);
        chk("t1_wb_data", wb_data, 64'd22);
        chk("t1_wb_tag", wb_tag, 5'd4);
        idle_step(1'b1);

        // 2: MADDH and 32-bit MUL sign extension
        step(1'b1, 1'b0, 6'd51, 5'd5, 64'h0008_0000_0000_0000, 64'd8192, 64'd1, 1'b0, acc, ordy);
        step(1'b1, 1'b0, 6'd0, 5'd6, 64'hFFFF_FFFF, 64'd2, 64'd0, 1'b0, acc, ordy);
        idle_step(1'b0);
        chk("t2_maddh", wb_data, 64'h2001);
        idle_step(1'b1);
        chk("t2_mul32", wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
        drain("t2_drain");

        // 3: credit limit with the consumer stalled
        k = 0; dacc = 0;
        for (int cy = 0; cy < 10; cy++) begin
            step(k < 6, 1'b1, 6'd0, 5'(10 + k), 64'(k + 1), 64'd3, 64'd0, 1'b0, acc, ordy);
            if (k < 6 && ordy) dacc++;
            if (acc) k++;
        end
        chk("t3_accepted", dacc, 4);
        chk("t3_ready_low", cmd_ready, 1'b0);
        for (int cy = 0; cy < 40 && !(k == 6 && exp_q.size() == 0); cy++) begin
            step(k < 6, 1'b1, 6'd0, 5'(10 + k), 64'(k + 1), 64'd3, 64'd0, 1'b1, acc, ordy);
            if (acc) k++;
        end
        chk("t3_all_issued", k, 6);
        drain("t3_drain");

        // 4: illegal function
        step(1'b1, 1'b0, 6'd7, 5'd3, 64'd9, 64'd9, 64'd9, 1'b1, acc, ordy);
        chk("t4_idle", idle, 1'b1);
        chk("t4_wb_valid", wb_valid, 1'b0);

        // 5: repeated tag 9 (stalls only with hazard tracking), then tag 0 back-to-back
        step(1'b1, 1'b1, 6'd3, 5'd9, 64'd77, 64'd88, 64'd0, 1'b0, acc, ordy);
        for (int cy = 0; cy < 5; cy++)
            step(1'b1, 1'b1, 6'd1, 5'd9, 64'd5, 64'd6, 64'd0, 1'b0, acc, ordy);
        cnt = 0;
        for (int cy = 0; cy < 12 && cnt == 0; cy++) begin
            step(1'b1, 1'b1, 6'd2, 5'd9, 64'd5, 64'd6, 64'd0, 1'b1, acc, ordy);
            if (acc) cnt++;
        end
        chk("t5_tag9_accepted", cnt, 1);
        drain("t5_drain9");
        step(1'b1, 1'b1, 6'd0, 5'd0, 64'd2, 64'd3, 64'd0, 1'b0, acc, ordy);
        chk("t5_tag0_first", ordy, 1'b1);
        step(1'b1, 1'b1, 6'd0, 5'd0, 64'd4, 64'd5, 64'd0, 1'b0, acc, ordy);
        chk("t5_tag0_second", ordy, 1'b1);
        drain("t5_drain0");

        // 6: reset with one result queued and two in flight
        step(1'b1, 1'b1, 6'd0, 5'd1, 64'd11, 64'd2, 64'd0, 1'b0, acc, ordy);
        step(1'b1, 1'b1, 6'd0, 5'd2, 64'd12, 64'd2, 64'd0, 1'b0, acc, ordy);
        step(1'b1, 1'b1, 6'd0, 5'd3, 64'd13, 64'd2, 64'd0, 1'b0, acc, ordy);
        cmd_valid = 1'b0;
        chk("t6_pre_wb_valid", wb_valid, 1'b1);
        chk("t6_pre_idle", idle, 1'b0);
        reset = 1'b0;
        cmd_valid = 1'b1;
        #1;
        chk("t6_rst_wb_valid", wb_valid, 1'b0);
        chk("t6_rst_idle", idle, 1'b1);
        chk("t6_rst_cmd_ready", cmd_ready, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        repeat (4) idle_step(1'b1);

        // Random traffic
        for (int cy = 0; cy < 400; cy++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: rf = 6'($urandom_range(0, 3));
                4:          rf = 6'd50;
                5:          rf = 6'd51;
                6:          rf = 6'($urandom_range(4, 49));
                default:    rf = 6'($urandom_range(52, 63));
            endcase
            step($urandom_range(0, 3) != 0, 1'($urandom), rf, 5'($urandom_range(0, 7)),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, acc, ordy);
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
